// File: rtl/router_fifo_pkt_if.sv
// Write/read channel bundle between the router core and one packet-aware output FIFO.
// The master drives requests and write data; the slave returns read data, occupancy and flags.
interface router_fifo_pkt_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int LEN_W  = 6
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              write_enb;
  logic              read_enb;
  logic              lfd_state;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic [CNT_W-1:0]  count;
  logic [LEN_W:0]    pkt_rem;
  logic              pkt_done;
  logic              overflow;
  logic              underflow;
  logic              hdr_err;

  modport master (
    output write_enb, read_enb, lfd_state, data_in,
    input  data_out, data_valid, empty, full, almost_full, count,
           pkt_rem, pkt_done, overflow, underflow, hdr_err
  );

  modport slave (
    input  write_enb, read_enb, lfd_state, data_in,
    output data_out, data_valid, empty, full, almost_full, count,
           pkt_rem, pkt_done, overflow, underflow, hdr_err
  );
endinterface

// File: rtl/router_fifo_pkt.sv
// Packet-aware synchronous FIFO: stores a header marker with each word, tracks the bytes
// left in the packet being read, and keeps sticky overflow/underflow/header-error flags.
module router_fifo_pkt #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AFULL_TH = DEPTH - 2,
  parameter int LEN_W    = 6
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 soft_reset,
  router_fifo_pkt_if.slave     bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int MW = DATA_W + 1;
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AFULL = CW'(AFULL_TH);
  localparam logic [CW-1:0] CNT_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [LEN_W:0] REM_ONE  = {{LEN_W{1'b0}}, 1'b1};

  logic [MW-1:0]     mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic [CW-1:0]     count_nxt_s;
  logic [DATA_W-1:0] data_out_r;
  logic              data_valid_r;
  logic [LEN_W:0]    pkt_rem_r;
  logic              pkt_done_r;
  logic              overflow_r;
  logic              underflow_r;
  logic              hdr_err_r;

  logic              empty_s;
  logic              full_s;
  logic              wr_ok_s;
  logic              rd_ok_s;
  logic [MW-1:0]     rd_word_s;
  logic [LEN_W:0]    hdr_len_s;

  assign empty_s   = (count_r == {CW{1'b0}});
  assign full_s    = (count_r == CNT_FULL);
  assign wr_ok_s   = bus.write_enb & ~full_s;
  assign rd_ok_s   = bus.read_enb & ~empty_s;
  assign rd_word_s = mem_r[rd_ptr_r];
  // Zero-extend before adding the parity byte so the largest length cannot wrap.
  assign hdr_len_s = {1'b0, rd_word_s[DATA_W-1 -: LEN_W]} + REM_ONE;

  // Next occupancy from the accepted write/read pair.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage array; contents survive reset, a soft reset only blocks the write.
  always_ff @(posedge clock) begin
    if (wr_ok_s && !soft_reset) begin
      mem_r[wr_ptr_r] <= {bus.lfd_state, bus.data_in};
    end
  end

  // Pointers, occupancy, registered read port, packet tracking and sticky flags.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      count_r      <= {CW{1'b0}};
      data_out_r   <= {DATA_W{1'b0}};
      data_valid_r <= 1'b0;
      pkt_rem_r    <= {(LEN_W+1){1'b0}};
      pkt_done_r   <= 1'b0;
      overflow_r   <= 1'b0;
      underflow_r  <= 1'b0;
      hdr_err_r    <= 1'b0;
    end else if (soft_reset) begin
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      count_r      <= {CW{1'b0}};
      data_out_r   <= {DATA_W{1'b0}};
      data_valid_r <= 1'b0;
      pkt_rem_r    <= {(LEN_W+1){1'b0}};
      pkt_done_r   <= 1'b0;
      overflow_r   <= 1'b0;
      underflow_r  <= 1'b0;
      hdr_err_r    <= 1'b0;
    end else begin
      count_r    <= count_nxt_s;
      pkt_done_r <= 1'b0;
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (bus.write_enb && full_s) begin
        overflow_r <= 1'b1;
      end
      if (bus.read_enb && empty_s) begin
        underflow_r <= 1'b1;
      end
      if (rd_ok_s) begin
        rd_ptr_r     <= rd_ptr_r + PTR_ONE;
        data_out_r   <= rd_word_s[DATA_W-1:0];
        data_valid_r <= 1'b1;
        if (rd_word_s[DATA_W]) begin
          pkt_rem_r <= hdr_len_s;
          if (pkt_rem_r != {(LEN_W+1){1'b0}}) begin
            hdr_err_r <= 1'b1;
          end
        end else if (pkt_rem_r != {(LEN_W+1){1'b0}}) begin
          pkt_rem_r <= pkt_rem_r - REM_ONE;
          if (pkt_rem_r == REM_ONE) begin
            pkt_done_r <= 1'b1;
          end
        end
      end else begin
        data_valid_r <= 1'b0;
      end
    end
  end

  assign bus.data_out    = data_out_r;
  assign bus.data_valid  = data_valid_r;
  assign bus.empty       = empty_s;
  assign bus.full        = full_s;
  assign bus.almost_full = (count_r >= CNT_AFULL);
  assign bus.count       = count_r;
  assign bus.pkt_rem     = pkt_rem_r;
  assign bus.pkt_done    = pkt_done_r;
  assign bus.overflow    = overflow_r;
  assign bus.underflow   = underflow_r;
  assign bus.hdr_err     = hdr_err_r;
endmodule

// File: doc/router_fifo_pkt.md
# router_fifo_pkt

Parametrised, packet-aware synchronous FIFO for the router output channels, the next generation of the fixed 16x9 router FIFO. It stores a header marker (lfd) bit alongside each data word and tracks the bytes remaining in the packet currently being read. It provides occupancy, almost-full and sticky error flags, and a registered output with a valid strobe. The write side is driven by the router FSM/register block; the read side is driven by the output port logic.

## Interface
- DATA_W, 8: data width in bits.
- DEPTH, 16: number of entries; power of 2, at least 4.
- AFULL_TH, DEPTH-2: occupancy at or above which almost_full asserts; 1 to DEPTH.
- LEN_W, 6: payload-length field width; the field sits at header bits [DATA_W-1 : DATA_W-LEN_W].
- clock  in  1  single clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- soft_reset  in  1  synchronous clear, same effect as reset.
- write_enb  in  1  write request.
- read_enb  in  1  read request.
- lfd_state  in  1  marks the current data_in as a packet header.
- data_in  in  DATA_W  write data.
- data_out  out  DATA_W  registered read data.
- data_valid  out  1  data_out holds a word read on the previous edge.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AFULL_TH.
- count  out  $clog2(DEPTH)+1  occupancy.
- pkt_rem  out  LEN_W+1  bytes still to be read in the current packet.
- pkt_done  out  1  one-cycle pulse when the last byte (parity) of a packet is read.
- overflow  out  1  sticky; set by a write request while full.
- underflow  out  1  sticky; set by a read request while empty.
- hdr_err  out  1  sticky; set when a header is read while pkt_rem != 0.

## Operation
- Storage: DEPTH x (DATA_W+1) entries; bit DATA_W holds lfd_state.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- A write is accepted iff write_enb && !full. It stores {lfd_state, data_in} at wr_ptr, then increments wr_ptr.
- A read is accepted iff read_enb && !empty. It sets data_out to the data bits at rd_ptr and data_valid to 1, then increments rd_ptr.
- When no read is accepted, data_valid is 0 and data_out holds its last value.
- Simultaneous write and read:
  - Both accepted: count is unchanged.
  - Full: only the read is accepted and overflow is set.
  - Empty: only the write is accepted and underflow is set; the new word cannot be read in the same cycle.
- Packet tracking, on an accepted read:
  - Lfd entry: pkt_rem is loaded with the length field + 1 (payload plus parity). If pkt_rem was nonzero, hdr_err is set.
  - Non-lfd entry with pkt_rem > 0: pkt_rem decrements. On the 1 -> 0 transition, pkt_done pulses in the same cycle that data_valid is high for that byte.
  - Non-lfd entry with pkt_rem == 0: no change, no pkt_done.
- Length arithmetic: the length field is zero-extended to LEN_W+1 bits before the +1, so a length of 2^LEN_W - 1 does not overflow.
- Reset (resetn low, or soft_reset at an edge):
  - All outputs except empty go to 0: data_out, data_valid, count, pkt_rem, pkt_done, full, almost_full and all sticky flags. Pointers go to 0.
  - empty goes to 1. Memory contents are not cleared.
- soft_reset overrides any read or write in the same cycle.
- Reset in the middle of a packet discards the partial packet. The next lfd read starts fresh, with no hdr_err.

## Timing
- All flags (empty, full, almost_full) decode combinationally from the registered count. Each flag updates in the cycle after the edge that accepted the operation.
- Write-to-read latency:
  - A word written at edge N makes empty fall after edge N.
  - The earliest read is accepted at edge N+1.
  - The word appears on data_out after edge N+1.
- Read latency is one cycle: read_enb sampled at edge N gives data_out and data_valid valid from edge N until edge N+1.
- Sticky flags set on the edge where the offending request is sampled. Only a reset clears them.
- resetn takes effect immediately, without waiting for a clock edge. Release is synchronous to the next rising edge.

## Test plan
- Reset: with resetn low, check empty=1, full=0, count=0, data_out=0, data_valid=0, pkt_rem=0 and every sticky flag 0. Pulse soft_reset after two writes -> count=0, empty=1.
- Fill to full (DEPTH=16):
  - Write header 0x39 (len 14, addr 01) with lfd=1, then 14 random payload bytes, then parity.
  - Expect count=16, full=1, and almost_full=1 from count=14.
  - A 17th write -> overflow=1, count stays 16.
- Packet read of that data:
  - After the header is read, pkt_rem=15.
  - After the 16th read: data_out equals the parity byte, pkt_done pulses exactly once, pkt_rem=0, empty=1.
  - A further read_enb -> underflow=1, data_valid=0.
- Simultaneous operations: at count=8, assert write and read together for 10 cycles -> count stays 8 and data comes out in order. When full, assert both -> read accepted, count=15, overflow=1.
- Wrap-around: run 40 single-word write/read pairs -> data is intact across pointer wrap and count never exceeds 1.
- Header error and mid-packet reset:
  - Read a header with len 4, then a second header after 2 bytes -> hdr_err=1 and pkt_rem reloads.
  - soft_reset with pkt_rem=3 -> pkt_rem=0. The next header read does not set hdr_err.
